// File: rtl/rtp_pkg.sv
// Shared definitions for the ambient-occlusion ray-tracing engine:
// Q16.16 constants, FSM state encoding and fixed-point helpers.
package rtp_pkg;

  localparam logic signed [31:0] ONE = 32'sh0001_0000;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_LOAD_RAY,
    ST_FETCH,
    ST_CALC_Z,
    ST_DIV,
    ST_FETCH1,
    ST_CALC_U,
    ST_FETCH2,
    ST_CALC_V,
    ST_NEXT_TRI,
    ST_RAY_DONE,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vec3_t;

  // Signed Q16.16 product: full 64-bit result, keep bits [47:16].
  function automatic logic signed [31:0] fx_mul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
    logic signed [63:0] p;
    p = a * b;
    return p[47:16];
  endfunction

  function automatic logic signed [31:0] fx_dot(input vec3_t a, input vec3_t b);
    return fx_mul(a.x, b.x) + fx_mul(a.y, b.y) + fx_mul(a.z, b.z);
  endfunction

endpackage

// File: rtl/fx_div.sv
// Signed Q16.16 divider: (num <<< 16) / den as a 48-step unsigned restoring
// divide on magnitudes; the sign is applied in the cycle flagged by done.
module fx_div (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] num,
  input  logic signed [31:0] den,
  output logic               done,
  output logic signed [31:0] quot
);

  logic [47:0] quo;
  logic [31:0] rem;
  logic [31:0] den_mag;
  logic [31:0] num_mag;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        neg;
  logic        busy;
  logic [5:0]  cnt;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    num_mag = num[31] ? 32'(-num) : 32'(num);
    rem_sh  = {1'b0, rem[30:0], quo[47]};
    diff    = rem_sh - {1'b0, den_mag};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo     <= '0;
      rem     <= '0;
      den_mag <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo     <= {num_mag, 16'h0000};
        rem     <= '0;
        den_mag <= den[31] ? 32'(-den) : 32'(den);
        neg     <= num[31] ^ den[31];
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        // The remainder stays below |den| <= 2^31, so bit 32 of diff is the borrow.
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[46:0], 1'b1};
        end else begin
          rem <= rem_sh[31:0];
          quo <= {quo[46:0], 1'b0};
        end
        cnt <= cnt + 6'd1;
        if (cnt == 6'd47) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quot = neg ? -$signed(quo[31:0]) : $signed(quo[31:0]);

endmodule

// File: rtl/rtp_rom.sv
// Read-only memory with a registered (1-cycle) read. Contents are loaded
// by backdoor into the array mem before reset is released.
module rtp_rom #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage arrays are never reset; a reset here would turn the array
  // into flops and lose the preloaded contents.
  always_ff @(posedge clock) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/top_ao.sv
// Ambient-occlusion engine top: sweeps all rays against all Woop triangles.
// Define AO_ANYHIT_EN to end each ray at its first accepted hit (shadow-ray mode).
module top_ao
  import rtp_pkg::*;
#(
  parameter int NUM_RAYS = 1024,
  parameter int NUM_TRIS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_hitT,
  output logic [31:0] io_ray_id_triangle,
  output logic        io_rtp_finish,
  output logic [63:0] io_counter_fdiv
);

  localparam int RAW   = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;
  localparam int TROWS = 3 * NUM_TRIS;
  localparam int TAW   = $clog2(TROWS);
  localparam int TIW   = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;

  state_t             state;
  logic [RAW-1:0]     ray_addr;
  logic [RAW-1:0]     cur_ray;
  logic [TIW-1:0]     tri_idx;
  logic [TAW-1:0]     row_base;
  logic [TAW-1:0]     row_addr;
  vec3_t              o_vec;
  vec3_t              d_vec;
  logic signed [31:0] tmax;
  logic               hit;
  logic signed [31:0] t_val;
  logic signed [31:0] u_val;

  logic signed [31:0] ray_ox, ray_oy, ray_oz;
  logic signed [31:0] ray_dx, ray_dy, ray_dz;
  logic signed [31:0] ray_ht;
  logic signed [31:0] tri_x, tri_y, tri_z, tri_w;

  vec3_t              r_row;
  logic signed [31:0] o_dot;
  logic signed [31:0] d_dot;
  logic signed [31:0] oz_val;
  logic signed [31:0] uv_val;
  logic signed [31:0] uv_sum;
  logic               div_start;
  logic               div_done;
  logic signed [31:0] div_quot;

  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_origx (.clock(clock), .addr(ray_addr), .data(ray_ox));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_origy (.clock(clock), .addr(ray_addr), .data(ray_oy));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_origz (.clock(clock), .addr(ray_addr), .data(ray_oz));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_dirx  (.clock(clock), .addr(ray_addr), .data(ray_dx));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_diry  (.clock(clock), .addr(ray_addr), .data(ray_dy));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_dirz  (.clock(clock), .addr(ray_addr), .data(ray_dz));
  rtp_rom #(.DEPTH(NUM_RAYS), .WIDTH(32), .AW(RAW)) u_ray_hitt  (.clock(clock), .addr(ray_addr), .data(ray_ht));

  rtp_rom #(.DEPTH(TROWS), .WIDTH(32), .AW(TAW)) u_tri_x (.clock(clock), .addr(row_addr), .data(tri_x));
  rtp_rom #(.DEPTH(TROWS), .WIDTH(32), .AW(TAW)) u_tri_y (.clock(clock), .addr(row_addr), .data(tri_y));
  rtp_rom #(.DEPTH(TROWS), .WIDTH(32), .AW(TAW)) u_tri_z (.clock(clock), .addr(row_addr), .data(tri_z));
  rtp_rom #(.DEPTH(TROWS), .WIDTH(32), .AW(TAW)) u_tri_w (.clock(clock), .addr(row_addr), .data(tri_w));

  // One datapath serves all three Woop rows; the FSM decides which row is live.
  always_comb begin
    r_row  = '{x: tri_x, y: tri_y, z: tri_z};
    o_dot  = fx_dot(o_vec, r_row);
    d_dot  = fx_dot(d_vec, r_row);
    oz_val = tri_w - o_dot;
    uv_val = (tri_w + o_dot) + fx_mul(t_val, d_dot);
    uv_sum = u_val + uv_val;
  end

  assign div_start = (state == ST_CALC_Z) && (d_dot != '0);

  fx_div u_div (
    .clock (clock),
    .reset (reset),
    .start (div_start),
    .num   (oz_val),
    .den   (d_dot),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= ST_RESET;
      ray_addr           <= '0;
      cur_ray            <= '0;
      tri_idx            <= '0;
      row_base           <= '0;
      row_addr           <= '0;
      o_vec              <= '0;
      d_vec              <= '0;
      tmax               <= '0;
      hit                <= 1'b0;
      t_val              <= '0;
      u_val              <= '0;
      io_hitT            <= '0;
      io_ray_id_triangle <= '0;
      io_rtp_finish      <= 1'b0;
      io_counter_fdiv    <= '0;
    end else begin
      case (state)
        ST_RESET: state <= ST_LOAD_RAY;

        ST_LOAD_RAY: begin
          o_vec    <= '{x: ray_ox, y: ray_oy, z: ray_oz};
          d_vec    <= '{x: ray_dx, y: ray_dy, z: ray_dz};
          tmax     <= ray_ht;
          hit      <= 1'b0;
          tri_idx  <= '0;
          row_base <= '0;
          row_addr <= '0;
          cur_ray  <= ray_addr;
          // Advance now so the ray memories prefetch the next ray meanwhile.
          if (ray_addr != RAW'(NUM_RAYS - 1)) ray_addr <= ray_addr + RAW'(1);
          state    <= ST_FETCH;
        end

        ST_FETCH: state <= ST_CALC_Z;

        ST_CALC_Z: begin
          if (d_dot == '0) begin
            state <= ST_NEXT_TRI;
          end else begin
            io_counter_fdiv <= io_counter_fdiv + 64'd1;
            row_addr        <= row_base + TAW'(1);
            state           <= ST_DIV;
          end
        end

        ST_DIV: begin
          if (div_done) begin
            t_val <= div_quot;
            state <= ST_FETCH1;
          end
        end

        ST_FETCH1: begin
          if (t_val <= 0 || t_val >= tmax) begin
            state <= ST_NEXT_TRI;
          end else begin
            row_addr <= row_base + TAW'(2);
            state    <= ST_CALC_U;
          end
        end

        ST_CALC_U: begin
          if (uv_val < 0) begin
            state <= ST_NEXT_TRI;
          end else begin
            u_val <= uv_val;
            state <= ST_FETCH2;
          end
        end

        ST_FETCH2: state <= ST_CALC_V;

        ST_CALC_V: begin
          if (uv_val < 0 || uv_sum > ONE) begin
            state <= ST_NEXT_TRI;
          end else begin
            tmax <= t_val;
            hit  <= 1'b1;
`ifdef AO_ANYHIT_EN
            state <= ST_RAY_DONE;
`else
            state <= ST_NEXT_TRI;
`endif
          end
        end

        ST_NEXT_TRI: begin
          if (tri_idx == TIW'(NUM_TRIS - 1)) begin
            state <= ST_RAY_DONE;
          end else begin
            tri_idx  <= tri_idx + TIW'(1);
            row_base <= row_base + TAW'(3);
            row_addr <= row_base + TAW'(3);
            state    <= ST_FETCH;
          end
        end

        ST_RAY_DONE: begin
          io_hitT            <= tmax;
          io_ray_id_triangle <= {hit, 31'(cur_ray)};
          if (cur_ray == RAW'(NUM_RAYS - 1)) begin
            io_rtp_finish <= 1'b1;
            state         <= ST_FINISH;
          end else begin
            state <= ST_LOAD_RAY;
          end
        end

        ST_FINISH: state <= ST_FINISH;

        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_top_ao.sv
// Self-checking bench for top_ao: directed and random scenes preloaded by
// backdoor, each ray result compared with a Q16.16 reference model.
module tb_top_ao;

  localparam int NR     = 4;
  localparam int NT     = 2;
  localparam int ONE    = 32'h0001_0000;
  localparam int BUDGET = 5000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_hitT;
  logic [31:0] io_ray_id_triangle;
  logic        io_rtp_finish;
  logic [63:0] io_counter_fdiv;

  top_ao #(.NUM_RAYS(NR), .NUM_TRIS(NT)) u_dut (
    .clock              (clock),
    .reset              (reset),
    .io_hitT            (io_hitT),
    .io_ray_id_triangle (io_ray_id_triangle),
    .io_rtp_finish      (io_rtp_finish),
    .io_counter_fdiv    (io_counter_fdiv)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Scene: per ray {ox, oy, oz, dx, dy, dz, hitT}; per row {x, y, z, w}.
  int ray_v [NR][7];
  int tri_m [3*NT][4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fmul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 16);
  endfunction

  function automatic int vdot(input int r, input int base, input int row);
    return fmul(ray_v[r][base], tri_m[row][0]) + fmul(ray_v[r][base+1], tri_m[row][1])
         + fmul(ray_v[r][base+2], tri_m[row][2]);
  endfunction

  task automatic model_ray(input int r, output logic [31:0] hit_t, output logic hit,
                           output int divs);
    int     tmax, oz, dz, t, u, v, row;
    longint q;
    tmax = ray_v[r][6];
    hit  = 1'b0;
    divs = 0;
    for (int k = 0; k < NT; k++) begin
      row = 3 * k;
      oz  = tri_m[row][3] - vdot(r, 0, row);
      dz  = vdot(r, 3, row);
      if (dz == 0) continue;
      divs++;
      q = (longint'(oz) * 65536) / longint'(dz);
      t = int'(q);
      if (t <= 0 || t >= tmax) continue;
      u = (tri_m[row+1][3] + vdot(r, 0, row+1)) + fmul(t, vdot(r, 3, row+1));
      if (u < 0) continue;
      v = (tri_m[row+2][3] + vdot(r, 0, row+2)) + fmul(t, vdot(r, 3, row+2));
      if (v < 0 || u + v > ONE) continue;
      tmax = t;
      hit  = 1'b1;
`ifdef AO_ANYHIT_EN
      break;
`endif
    end
    hit_t = tmax;
  endtask

  // ---------------- scene construction ----------------
  function automatic int srand(input int lo, input int hi);
    return lo + int'($urandom_range(32'(hi - lo), 0));
  endfunction

  task automatic set_ray(input int i, input int ox, input int oy, input int oz,
                         input int dx, input int dy, input int dz, input int h);
    ray_v[i] = '{ox, oy, oz, dx, dy, dz, h};
  endtask

  // Unit triangle on plane z=c facing +/-z, optional (u,v) offsets.
  task automatic set_tri(input int k, input int c, input int w1, input int w2);
    tri_m[3*k]   = '{0, 0, ONE, c};
    tri_m[3*k+1] = '{ONE, 0, 0, w1};
    tri_m[3*k+2] = '{0, ONE, 0, w2};
  endtask

  task automatic load_mems();
    for (int i = 0; i < NR; i++) begin
      u_dut.u_ray_origx.mem[i] = ray_v[i][0];
      u_dut.u_ray_origy.mem[i] = ray_v[i][1];
      u_dut.u_ray_origz.mem[i] = ray_v[i][2];
      u_dut.u_ray_dirx.mem[i]  = ray_v[i][3];
      u_dut.u_ray_diry.mem[i]  = ray_v[i][4];
      u_dut.u_ray_dirz.mem[i]  = ray_v[i][5];
      u_dut.u_ray_hitt.mem[i]  = ray_v[i][6];
    end
    for (int j = 0; j < 3*NT; j++) begin
      u_dut.u_tri_x.mem[j] = tri_m[j][0];
      u_dut.u_tri_y.mem[j] = tri_m[j][1];
      u_dut.u_tri_z.mem[j] = tri_m[j][2];
      u_dut.u_tri_w.mem[j] = tri_m[j][3];
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hitT"},   64'(io_hitT), 64'd0);
    check({tag, "_id"},     64'(io_ray_id_triangle), 64'd0);
    check({tag, "_finish"}, 64'(io_rtp_finish), 64'd0);
    check({tag, "_fdiv"},   io_counter_fdiv, 64'd0);
  endtask

  // ---------------- scenario runner ----------------
  task automatic run_scene(input string name, input bit abort);
    logic [31:0] exp_t [NR];
    logic        exp_h [NR];
    int          exp_d [NR];
    int          sum_d, idx, cyc;
    logic [63:0] prev;

    sum_d = 0;
    for (int i = 0; i < NR; i++) begin
      model_ray(i, exp_t[i], exp_h[i], exp_d[i]);
      sum_d += exp_d[i];
    end

    @(negedge clock);
    reset = 1'b1;
    load_mems();
    @(negedge clock);
    check_zero({name, "_rst"});
    reset = 1'b0;

    if (abort) begin
      // Wait until ray 0 has reported and a divide for ray 1 is under way.
      cyc = 0;
      while (!(io_hitT != 0 && io_ray_id_triangle[30:0] == 0 &&
               io_counter_fdiv > 64'(exp_d[0])) && cyc < BUDGET) begin
        @(negedge clock);
        cyc++;
      end
      check({name, "_abort_wait"}, 64'(cyc < BUDGET), 64'd1);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1 check_zero({name, "_abort"});
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
    end

    prev = '0;
    idx  = 0;
    cyc  = 0;
    while (idx < NR && cyc < BUDGET) begin
      @(negedge clock);
      cyc++;
      if ({io_hitT, io_ray_id_triangle} != prev) begin
        prev = {io_hitT, io_ray_id_triangle};
        check($sformatf("%s_r%0d_hitT", name, idx), 64'(io_hitT), 64'(exp_t[idx]));
        check($sformatf("%s_r%0d_id", name, idx), 64'(io_ray_id_triangle),
              64'({exp_h[idx], 31'(idx)}));
        check($sformatf("%s_r%0d_finish", name, idx), 64'(io_rtp_finish),
              64'(idx == NR - 1));
        idx++;
      end
    end
    check({name, "_rays_seen"}, 64'(idx), 64'(NR));
    repeat (3) @(negedge clock);
    check({name, "_fdiv"}, io_counter_fdiv, 64'(sum_d));
    check({name, "_finish_hold"}, 64'(io_rtp_finish), 64'd1);
  endtask

  initial begin
    // Scene A: triangles at z=8 then z=4; hit, miss, parallel, hitT too short.
    set_tri(0, 8 * ONE, 0, 0);
    set_tri(1, 4 * ONE, 0, 0);
    set_ray(0, ONE / 4, ONE / 4, 0, 0, 0, ONE, 100 * ONE);
    set_ray(1, 2 * ONE, 2 * ONE, 0, 0, 0, ONE, 100 * ONE);
    set_ray(2, ONE / 4, ONE / 4, 0, ONE, 0, 0, 100 * ONE);
    set_ray(3, ONE / 4, ONE / 4, 0, 0, 0, ONE, 3 * ONE);
    run_scene("A", 1'b0);

    // Reset in the middle of ray 1's divide, then a full rerun.
    run_scene("A_abort", 1'b1);

    // Scene B: triangles at z=5 and z=-5; behind-origin and u+v edges.
    set_tri(0, 5 * ONE, 0, 0);
    set_tri(1, -5 * ONE, 0, 0);
    set_ray(0, ONE / 4, ONE / 4, 0, 0, 0, ONE, 100 * ONE);
    set_ray(1, ONE / 4, ONE / 4, 0, 0, 0, -ONE, 100 * ONE);
    set_ray(2, ONE / 2, ONE / 2, 0, 0, 0, ONE, 100 * ONE);
    set_ray(3, ONE / 2, ONE / 2 + 1, 0, 0, 0, ONE, 100 * ONE);
    run_scene("B", 1'b0);

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < NT; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          set_tri(k, srand(-12 * ONE, 12 * ONE), srand(-ONE / 4, ONE / 4),
                  srand(-ONE / 4, ONE / 4));
        end else begin
          for (int r = 0; r < 3; r++)
            tri_m[3*k+r] = '{srand(-2 * ONE, 2 * ONE), srand(-2 * ONE, 2 * ONE),
                             srand(-2 * ONE, 2 * ONE), srand(-8 * ONE, 8 * ONE)};
        end
      end
      for (int i = 0; i < NR; i++) begin
        int dz;
        dz = ($urandom_range(7, 0) == 0) ? 0 : srand(ONE / 2, 2 * ONE);
        if ($urandom_range(1, 0) == 1) dz = -dz;
        set_ray(i, srand(-ONE / 4, ONE), srand(-ONE / 4, ONE), srand(-ONE, ONE),
                srand(-ONE / 8, ONE / 8), srand(-ONE / 8, ONE / 8), dz,
                srand(ONE, 20 * ONE));
      end
      run_scene($sformatf("R%0d", s), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top_ao.md
# top_ao

Ambient-occlusion ray-tracing engine top. It sweeps every ray in an internal ray memory, tests each ray against every triangle in an internal triangle memory, and reports one result per ray. The intersection test is Woop-style unit-triangle arithmetic in Q16.16 fixed point. It sits at the top of the RTP test hierarchy, and its memories are preloaded by backdoor before reset is released.

## Interface
Parameters:
- NUM_RAYS, 1024 — rays processed; ray address width is clog2(NUM_RAYS).
- NUM_TRIS, 1024 — triangles; each triangle occupies 3 consecutive memory rows (3·NUM_TRIS rows).

Ports:
- clock  in  1  — single clock; all state is updated on its rising edge.
- reset  in  1  — asynchronous, active-high.
- io_hitT  out  32  — Q16.16 hit distance for the most recently completed ray (initial ray hitT if no hit).
- io_ray_id_triangle  out  32  — bit31 = hit flag; bits30:0 = index of the most recently completed ray.
- io_rtp_finish  out  1  — high once all NUM_RAYS rays are complete; sticky until reset.
- io_counter_fdiv  out  64  — count of divisions started since reset.

## Operation
- Ray memories (NUM_RAYS deep, 32-bit, Q16.16): Ray_origx, Ray_origy, Ray_origz, Ray_dirx, Ray_diry, Ray_dirz, Ray_hitT.
- Triangle memories (3·NUM_TRIS deep, 32-bit): TRI_RAM_x, TRI_RAM_y, TRI_RAM_z, TRI_RAM_w. Row r holds the Woop matrix row (x,y,z,w).
- Every memory is an instance whose storage array is named mem. Memories have no reset, have no write port, and use a synchronous 1-cycle read.
- Per ray, the running hit distance starts as tmax = Ray_hitT[ray], and the hit flag starts at 0.
- Per triangle k, using rows 3k, 3k+1 and 3k+2:
  - Oz = w0 − o·r0 and Dz = d·r0.
  - If Dz = 0, reject without a division.
  - Otherwise t = Oz/Dz and io_counter_fdiv increments.
  - Reject if t ≤ 0 or t ≥ tmax.
  - u = (w1 + o·r1) + t·(d·r1); reject if u < 0.
  - v = (w2 + o·r2) + t·(d·r2); reject if v < 0 or u+v > 0x0001_0000.
  - On acceptance: tmax = t and the hit flag = 1.
- Arithmetic rules:
  - Multiply: signed 32×32→64, result is bits[47:16].
  - Add: 32-bit wrap.
  - Divide: signed (Oz<<<16)/Dz, computed as an unsigned restoring divide on magnitudes (48 iterations, 1 bit per cycle), sign applied after; the quotient is truncated to 32 bits.
- State machine:
  - RESET → LOAD_RAY → FETCH (row 3k) → CALC_Z → DIV → FETCH1 → CALC_U → FETCH2 → CALC_V → NEXT_TRI.
  - NEXT_TRI returns to FETCH, or goes to RAY_DONE after the last triangle.
  - Any reject goes directly to NEXT_TRI.
  - RAY_DONE → LOAD_RAY, or → FINISH after the last ray.
  - FINISH is absorbing.
- At RAY_DONE, io_hitT ← tmax and io_ray_id_triangle ← {hit, ray}.

## Timing
- Reset value of every output is 0; the FSM is in RESET and all counters are 0.
- The first LOAD_RAY starts on the first clock edge after reset deasserts.
- Each memory read costs 1 cycle. The divide costs 48 cycles plus 1 cycle for sign fixup.
- Outputs update on the cycle after the RAY_DONE edge and hold until the next RAY_DONE.
- io_rtp_finish rises in the same cycle that the last ray's result appears.
- Reset asserted mid-operation aborts the current ray immediately and clears all outputs; processing restarts at ray 0.
- io_counter_fdiv is 64-bit and does not saturate.

## Configuration
- AO_ANYHIT_EN defined: the first accepted hit ends the ray; remaining triangles are skipped and the FSM goes straight to RAY_DONE. This is the AO shadow-ray mode.
- Not defined: all triangles are tested, giving closest-hit semantics; tmax shrinks on each acceptance.

## Structure
- Shared package rtp_pkg holds:
  - the Q16.16 ONE constant (0x0001_0000);
  - the state enum;
  - the fixed-point multiply function.
- One sub-module, rtp_rom: parameterized depth/width, synchronous read, array mem. It is instantiated 11 times.
- The divider stays inline or optionally forms a second sub-module, fx_div.

## Test plan
- NUM_RAYS=1, NUM_TRIS=1, unit triangle on plane z=5 facing the ray, origin (0.25,0.25,0), direction (0,0,1), hitT=100.0 → io_hitT=0x0005_0000, io_ray_id_triangle=0x8000_0000, io_counter_fdiv=1, finish=1.
- Same ray with origin (2,2,0), outside the triangle → io_hitT=0x0064_0000, hit flag 0, io_counter_fdiv=1.
- Direction parallel to the triangle plane (Dz=0) → no hit, io_counter_fdiv=0.
- Triangle behind the origin (t=−5) → no hit; triangle with t=5 and hitT=3 → no hit.
- Two triangles at t=8 then t=4:
  - without AO_ANYHIT_EN → io_hitT=0x0004_0000, io_counter_fdiv=2;
  - with AO_ANYHIT_EN → io_hitT=0x0008_0000, io_counter_fdiv=1.
- Assert reset mid-divide on ray 1 of 4 → all outputs return to 0 at once; the rerun yields the same final results and the same io_counter_fdiv as a clean run.
